btn_debounce_array: RTL and testbench
=====================================

# btn_debounce_array

Parametrised N-channel push-button conditioner; next generation of the single-button debouncer for the stopwatch front panel. All channels share one sample-tick prescaler. Each channel synchronises, samples and debounces its raw input with hysteresis, then emits a debounced level plus one-clock press and release pulses. Optional auto-repeat turns a held button into periodic press pulses for digit setting. Sits between the board buttons and the stopwatch control FSM.

## Interface
- N, 4, number of button channels (≥1)
- CLK_HZ, 100_000_000, system clock frequency
- SAMPLE_HZ, 1_000, sample-tick rate; DIV = CLK_HZ/SAMPLE_HZ, must be ≥2
- DEPTH, 8, samples per channel shift register (≥2)
- REPEAT_DELAY, 500, ticks held before first auto-repeat (≥1)
- REPEAT_PERIOD, 100, ticks between subsequent auto-repeats (≥1)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_btn  in  N  raw asynchronous button inputs, 1 = pressed
- o_level  out  N  debounced level per channel
- o_press  out  N  one-clk pulse on debounced rise (and on auto-repeat)
- o_release  out  N  one-clk pulse on debounced fall
- o_tick  out  1  shared sample tick, one clk wide every DIV clks

## Operation
- Prescaler: counter 0..DIV-1, wraps to 0; o_tick = 1 in the cycle the counter equals DIV-1. Single clock domain: the tick is a clock enable, never a clock.
- Per channel: 2-FF synchroniser on i_btn[k]; on each tick, sh <= {sh[DEPTH-2:0], sync}.
- Hysteresis: sh all ones and o_level=0 -> o_level<=1, o_press<=1. sh all zeros and o_level=1 -> o_level<=0, o_release<=1. Any mixed pattern holds o_level. Pulses are cleared the following clk.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- Press and release never assert together on one channel.

## Timing
- Reset: prescaler 0, synchronisers 0, sh 0, all outputs 0 (o_level, o_press, o_release, o_tick).
- Input stable from clk t: sync valid at t+2; level change after at most DEPTH ticks; worst latency 2 + DEPTH*DIV + 1 clks; minimum 2 + (DEPTH-1)*DIV + 2.
- Pulse of width < (DEPTH-1)*DIV clks never changes o_level.
- o_press/o_release: exactly 1 clk wide, registered, coincident with the o_level edge.
- reset_n low mid-press: all outputs drop to 0 immediately; no release pulse is generated, before or after reset.
- Prescaler wrap is exact: ticks spaced DIV clks with no skipped or double tick.

## Configuration
- BTN_REPEAT_EN defined: per-channel repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)), cleared when o_level=0. While o_level=1 it increments on tick. At REPEAT_DELAY ticks after the level rise: one-clk o_press, counter reloads. Thereafter o_press every REPEAT_PERIOD ticks until release. Release clears the counter in the same cycle as o_release.
- Undefined: no repeat logic; o_press only on debounced rise.

## Structure
- Package btn_pkg: function computing DIV with an elaboration-time check (DIV≥2, DEPTH≥2), counter-width helper, default SAMPLE_HZ/DEPTH constants shared with other panel blocks.
- Sub-module btn_debounce_ch: one channel (synchroniser, shift register, hysteresis, optional repeat), instantiated N times by generate. The prescaler stays in the top.

## Test plan
Bench parameters: CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), DEPTH=4, N=4, REPEAT_DELAY=5, REPEAT_PERIOD=2.
- Reset held 20 clks, inputs toggling -> all outputs 0; o_tick first high 10 clks after release, then every 10.
- i_btn[0] 0->1 held 100 clks -> o_level[0] rises within 43 clks; exactly one 1-clk o_press[0]; channels 1-3 silent.
- i_btn[1] toggles every 7 clks for 60 clks then stays 1 -> exactly one o_press[1]; no o_release[1].
- i_btn[2] high for 15 clks only -> o_level[2] stays 0, no pulses.
- Channels 0 and 3 released in the same clk after being debounced high -> o_release[0] and o_release[3] in the same cycle, o_level both 0.
- BTN_REPEAT_EN, i_btn[0] held 200 clks -> press at level rise, repeat 50 clks later, then every 20 clks. With reset_n pulsed low mid-hold -> outputs 0 at once and no o_release afterwards.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the front-panel button blocks.
// Used by btn_debounce_array and btn_debounce_ch.
package btn_pkg;

  localparam int SAMPLE_HZ_DEF = 1_000;
  localparam int DEPTH_DEF     = 8;

  function automatic int calc_div(
    input int clk_hz,
    input int sample_hz
  );
    return clk_hz / sample_hz;
  endfunction

  function automatic bit cfg_ok(
    input int n,
    input int div,
    input int depth,
    input int rpt_delay,
    input int rpt_period
  );
    return (n >= 1) && (div >= 2) &&
           (depth >= 2) &&
           (rpt_delay >= 1) &&
           (rpt_period >= 1);
  endfunction

  function automatic int cnt_w(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, sample shift register, hysteresis.
// Auto-repeat of o_press is built only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  logic [1:0]       sync;
  logic [DEPTH-1:0] sh;
  logic             rise;
  logic             fall;
  logic             rfire;

  assign rise = (&sh) & ~o_level;
  assign fall = ~(|sh) & o_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      sh   <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (tick) sh <= {sh[DEPTH-2:0], sync[1]};
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_DELAY, REPEAT_PERIOD);

  logic [RW-1:0] rcnt;
  logic [RW-1:0] rlim;
  logic          rpt;

  // First repeat waits the long delay, later ones the short period.
  assign rlim  = rpt ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
  assign rfire = o_level & ~fall & (rcnt == rlim);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt <= '0;
      rpt  <= 1'b0;
    end else if (!o_level || fall) begin
      rcnt <= '0;
      rpt  <= 1'b0;
    end else if (rfire) begin
      rcnt <= '0;
      rpt  <= 1'b1;
    end else if (tick) begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign rfire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      o_press   <= rise | rfire;
      o_release <= fall;
      if (rise)      o_level <= 1'b1;
      else if (fall) o_level <= 1'b0;
    end
  end

endmodule

// File: rtl/btn_debounce_array.sv
// N-channel button conditioner with a shared sample-tick prescaler.
// Define BTN_REPEAT_EN to enable auto-repeat press pulses.
module btn_debounce_array
  import btn_pkg::*;
#(
  parameter int N             = 4,
  parameter int CLK_HZ        = 100_000_000,
  parameter int SAMPLE_HZ     = SAMPLE_HZ_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] i_btn,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic         o_tick
);

  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int PW  = $clog2(DIV);

  if (!cfg_ok(N, DIV, DEPTH,
              REPEAT_DELAY, REPEAT_PERIOD)) begin : g_cfg_err
    $error("btn_debounce_array: bad configuration");
  end

  logic [PW-1:0] pcnt;

  assign o_tick = (pcnt == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pcnt <= '0;
    else if (o_tick) pcnt <= '0;
    else             pcnt <= pcnt + 1'b1;
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
`ifdef BTN_REPEAT_EN
    btn_debounce_ch #(
      .DEPTH        (DEPTH),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (o_tick),
      .btn      (i_btn[k]),
      .o_level  (o_level[k]),
      .o_press  (o_press[k]),
      .o_release(o_release[k])
    );
`else
    btn_debounce_ch #(
      .DEPTH(DEPTH)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (o_tick),
      .btn      (i_btn[k]),
      .o_level  (o_level[k]),
      .o_press  (o_press[k]),
      .o_release(o_release[k])
    );
`endif
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Scoreboard bench for btn_debounce_array (DIV=10, DEPTH=4, N=4).
// Compile with BTN_REPEAT_EN to exercise the auto-repeat path.
module tb_btn_debounce_array;

  localparam int N = 4;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] i_btn   = '0;
  logic [N-1:0] o_level;
  logic [N-1:0] o_press;
  logic [N-1:0] o_release;
  logic         o_tick;

  btn_debounce_array #(
    .N            (N),
    .CLK_HZ       (1000),
    .SAMPLE_HZ    (100),
    .DEPTH        (4),
    .REPEAT_DELAY (5),
    .REPEAT_PERIOD(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_btn    (i_btn),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_tick   (o_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] level;
    int           gap;
  } ev_t;

  ev_t q[$];
  int  checks   = 0;
  int  passes   = 0;
  int  cyc      = 0;
  int  last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(
    input string nm,
    input int    act,
    input int    exp
  );
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endfunction

  function automatic void chk_rng(
    input string nm,
    input int    act,
    input int    lo,
    input int    hi
  );
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d expected %0d..%0d",
                  nm, act, lo, hi);
  endfunction

  function automatic ev_t mk(
    input logic [N-1:0] p,
    input logic [N-1:0] r,
    input logic [N-1:0] l,
    input int           g
  );
    ev_t e;
    e.press = p;
    e.rel   = r;
    e.level = l;
    e.gap   = g;
    return e;
  endfunction

  // Monitor: every pulse cycle must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (reset_n && ((|o_press) || (|o_release))) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse",
            int'({o_press, o_release}), 0);
      end else begin
        e = q.pop_front();
        chk("press_mask", int'(o_press), int'(e.press));
        chk("release_mask", int'(o_release), int'(e.rel));
        chk("level_at_pulse", int'(o_level), int'(e.level));
        if (e.gap != 0)
          chk("pulse_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    #2 reset_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_btn = 4'(i * 5);
      #1;
      chk("reset_outputs",
          int'({o_level, o_press, o_release, o_tick}), 0);
    end
    @(negedge clk);
    i_btn   = '0;
    reset_n = 1'b1;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_tick && n < 30);
    chk_rng("first_tick", n, 9, 10);
    for (int t = 0; t < 3; t++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_tick && n < 30);
      chk("tick_gap", n, 10);
    end
    clks(60);

`ifndef BTN_REPEAT_EN
    q.push_back(mk(4'b0001, 4'b0000, 4'b0001, 0));
    i_btn[0] = 1'b1;
    n = 0;
    while (!o_level[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_rng("ch0_rise_latency", n, 34, 43);
    clks(100 - n);
    chk("level_after_ch0", int'(o_level), 1);

    q.push_back(mk(4'b0010, 4'b0000, 4'b0011, 0));
    for (int t = 0; t < 9; t++) begin
      i_btn[1] = ~i_btn[1];
      clks(7);
    end
    clks(60);
    chk("level_after_ch1", int'(o_level), 3);

    i_btn[2] = 1'b1;
    clks(15);
    i_btn[2] = 1'b0;
    clks(60);
    chk("level_after_glitch", int'(o_level), 3);

    q.push_back(mk(4'b1000, 4'b0000, 4'b1011, 0));
    i_btn[3] = 1'b1;
    clks(60);
    chk("level_after_ch3", int'(o_level), 11);

    q.push_back(mk(4'b0000, 4'b1001, 4'b0010, 0));
    i_btn[0] = 1'b0;
    i_btn[3] = 1'b0;
    clks(60);
    chk("level_after_release", int'(o_level), 2);
`else
    q.push_back(mk(4'b0001, 4'b0000, 4'b0001, 0));
    q.push_back(mk(4'b0001, 4'b0000, 4'b0001, 50));
    for (int t = 0; t < 3; t++)
      q.push_back(mk(4'b0001, 4'b0000, 4'b0001, 20));
    i_btn[0] = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("repeat_events_left", q.size(), 0);
    clks(5);
    reset_n = 1'b0;
    #1;
    chk("midhold_reset_outputs",
        int'({o_level, o_press, o_release, o_tick}), 0);
    i_btn = '0;
    clks(3);
    reset_n = 1'b1;
    clks(100);
    chk("level_after_reset", int'(o_level), 0);
`endif

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
